// File: rtl/ls_axi_bridge_if.sv
// Signal bundles for ls_axi_bridge: the core load/store port and the AXI4 master port.
// master = side that issues requests, slave = side that answers them.

interface ls_core_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req_ren;
    logic                  req_wen;
    logic [DATA_W/8-1:0]   req_wsel;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W-1:0]     req_rdata;
    logic                  req_rvalid;
    logic                  req_bvalid;
    logic                  req_flush;

    modport master (
        output req_ren, req_wen, req_wsel, req_addr, req_wdata, req_flush,
        input  req_rdata, req_rvalid, req_bvalid
    );
    modport slave (
        input  req_ren, req_wen, req_wsel, req_addr, req_wdata, req_flush,
        output req_rdata, req_rvalid, req_bvalid
    );
endinterface

interface ls_axi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]     araddr;
    logic [2:0]            arsize;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;
    logic [ADDR_W-1:0]     awaddr;
    logic [2:0]            awsize;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output araddr, arsize, arvalid, rready,
               awaddr, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  arready, rdata, rresp, rlast, rvalid, awready, wready, bresp, bvalid
    );
    modport slave (
        input  araddr, arsize, arvalid, rready,
               awaddr, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rdata, rresp, rlast, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ls_axi_bridge.sv
// Core load/store port to AXI4 bridge: posted-write buffer, one outstanding read, load flush.
// Optional LS_BRIDGE_ERR_EN adds a sticky bus_err output for non-OKAY responses.

module ls_axi_bridge #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WBUF_DEPTH = 4
) (
    input  logic      clk,
    input  logic      resetn,
    ls_core_if.slave  core,
    ls_axi_if.master  axi
`ifdef LS_BRIDGE_ERR_EN
    ,
    output logic      bus_err
`endif
);
    localparam int       STRB_W = DATA_W / 8;
    localparam int       IDX_W  = $clog2(WBUF_DEPTH);
    localparam int       PTR_W  = IDX_W + 1;
    localparam bit [2:0] AXSIZE = (DATA_W == 64) ? 3'd3 : 3'd2;

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wstate_e;
    typedef enum logic [2:0] {R_IDLE, R_DRAIN, R_AR, R_R, R_DONE} rstate_e;

    // ---------------- posted-write buffer ----------------
    logic [ADDR_W-1:0] buf_addr_q [WBUF_DEPTH];
    logic [DATA_W-1:0] buf_data_q [WBUF_DEPTH];
    logic [STRB_W-1:0] buf_strb_q [WBUF_DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic              empty, full, push, pop;

    wstate_e wstate_q, wstate_d;
    logic    aw_done_q, aw_done_d, w_done_q, w_done_d;

    rstate_e           rstate_q, rstate_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ren_active, drain_ok;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]) && (wptr_q[IDX_W] != rptr_q[IDX_W]);

    assign ren_active      = (rstate_q != R_IDLE);
    assign push            = core.req_wen & ~full & ~ren_active;
    assign core.req_bvalid = push;

    assign wptr_d = wptr_q + PTR_W'(push);
    assign rptr_d = rptr_q + PTR_W'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr_q[wptr_q[IDX_W-1:0]] <= core.req_addr;
            buf_data_q[wptr_q[IDX_W-1:0]] <= core.req_wdata;
            buf_strb_q[wptr_q[IDX_W-1:0]] <= core.req_wsel;
        end
    end

    // ---------------- write drain FSM ----------------
    assign axi.awaddr = buf_addr_q[rptr_q[IDX_W-1:0]];
    assign axi.awsize = AXSIZE;
    assign axi.wdata  = buf_data_q[rptr_q[IDX_W-1:0]];
    assign axi.wstrb  = buf_strb_q[rptr_q[IDX_W-1:0]];
    assign axi.wlast  = 1'b1;

    always_comb begin
        wstate_d    = wstate_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        pop         = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (!empty) wstate_d = W_REQ;
            end
            W_REQ: begin
                // AW and W complete independently; wait for both before B.
                axi.awvalid = ~aw_done_q;
                axi.wvalid  = ~w_done_q;
                aw_done_d   = aw_done_q | axi.awready;
                w_done_d    = w_done_q | axi.wready;
                if (aw_done_d && w_done_d) wstate_d = W_RESP;
            end
            W_RESP: begin
                axi.bready = 1'b1;
                if (axi.bvalid) begin
                    pop       = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // ---------------- read FSM ----------------
    // A same-cycle store push counts as pending so the load cannot overtake it.
    assign drain_ok       = empty & ~push & (wstate_q == W_IDLE);
    assign axi.araddr     = raddr_q;
    assign axi.arsize     = AXSIZE;
    assign core.req_rdata = rdata_q;

    always_comb begin
        rstate_d        = rstate_q;
        drop_d          = drop_q;
        raddr_d         = raddr_q;
        rdata_d         = rdata_q;
        axi.arvalid     = 1'b0;
        axi.rready      = 1'b0;
        core.req_rvalid = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                drop_d = 1'b0;
                if (core.req_ren && !core.req_flush) begin
                    raddr_d  = core.req_addr;
                    rstate_d = drain_ok ? R_AR : R_DRAIN;
                end
            end
            R_DRAIN: begin
                if (core.req_flush)  rstate_d = R_IDLE;
                else if (drain_ok)   rstate_d = R_AR;
            end
            R_AR: begin
                axi.arvalid = 1'b1;
                if (core.req_flush) drop_d = 1'b1;
                if (axi.arready)    rstate_d = R_R;
            end
            R_R: begin
                axi.rready = 1'b1;
                if (core.req_flush) drop_d = 1'b1;
                if (axi.rvalid) begin
                    rdata_d  = axi.rdata;
                    rstate_d = R_DONE;
                end
            end
            R_DONE: begin
                core.req_rvalid = ~drop_q;
                drop_d          = 1'b0;
                rstate_d        = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            wstate_q  <= W_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rstate_q  <= R_IDLE;
            drop_q    <= 1'b0;
            raddr_q   <= '0;
            rdata_q   <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            wstate_q  <= wstate_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rstate_q  <= rstate_d;
            drop_q    <= drop_d;
            raddr_q   <= raddr_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef LS_BRIDGE_ERR_EN
    logic err_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            err_q <= 1'b0;
        else if ((rstate_q == R_R && axi.rvalid && axi.rresp != 2'b00) ||
                 (pop && axi.bresp != 2'b00))
            err_q <= 1'b1;
    end
    assign bus_err = err_q;

    logic unused_rlast;
    assign unused_rlast = axi.rlast;
`else
    // Single-beat only and responses are not reported in this build.
    logic unused_resp;
    assign unused_resp = ^{axi.rresp, axi.bresp, axi.rlast};
`endif

endmodule

// File: tb/tb_ls_axi_bridge.sv
// Scoreboard bench for ls_axi_bridge: directed stimulus pushes expectations, monitors pop and compare.

module tb_ls_axi_bridge;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    ls_core_if #(.ADDR_W(AW), .DATA_W(DW)) core();
    ls_axi_if  #(.ADDR_W(AW), .DATA_W(DW)) axi();
`ifdef LS_BRIDGE_ERR_EN
    logic bus_err;
`endif

    ls_axi_bridge #(.ADDR_W(AW), .DATA_W(DW), .WBUF_DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .core   (core),
        .axi    (axi)
`ifdef LS_BRIDGE_ERR_EN
        ,
        .bus_err(bus_err)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event (cycle %0d)", nm, cyc);
    endtask

    // scoreboard queues
    logic [31:0] exp_ar[$];
    logic [31:0] exp_aw[$];
    logic [36:0] exp_w[$];
    logic [31:0] exp_rd[$];
    logic [31:0] rsrc[$];

    // AXI slave model
    bit       ar_rdy = 1'b1, aw_rdy = 1'b1, w_rdy = 1'b1;
    int       r_dly = 0, b_dly = 0;
    logic [1:0] bresp_cfg = 2'b00;
    assign axi.arready = ar_rdy;
    assign axi.awready = aw_rdy;
    assign axi.wready  = w_rdy;

    bit s_ar, s_r, s_aw, s_w, s_b;
    bit r_busy = 0, b_busy = 0, aw_seen = 0, w_seen = 0;
    int r_wait = 0, b_wait = 0;
    int n_ar = 0, n_r = 0, n_b = 0, b_cyc = 0;

    initial begin
        axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b1;
        axi.bvalid = 1'b0; axi.bresp = 2'b00;
        forever begin
            @(negedge clk);
            s_ar = axi.arvalid & axi.arready;
            s_r  = axi.rvalid & axi.rready;
            s_aw = axi.awvalid & axi.awready;
            s_w  = axi.wvalid & axi.wready;
            s_b  = axi.bvalid & axi.bready;
            if (s_ar) begin r_busy = 1; r_wait = r_dly; n_ar++; end
            if (s_r)  begin r_busy = 0; n_r++; end
            if (s_b)  begin b_busy = 0; n_b++; b_cyc = cyc; end
            if (s_aw) aw_seen = 1;
            if (s_w)  w_seen = 1;
            if (aw_seen && w_seen && !b_busy) begin
                b_busy = 1; b_wait = b_dly; aw_seen = 0; w_seen = 0;
            end
            @(posedge clk); #1;
            if (s_r) axi.rvalid = 1'b0;
            else if (r_busy && !axi.rvalid) begin
                if (r_wait == 0) begin
                    axi.rvalid = 1'b1;
                    axi.rdata  = (rsrc.size() != 0) ? rsrc.pop_front() : 32'h0;
                end else r_wait--;
            end
            if (s_b) axi.bvalid = 1'b0;
            else if (b_busy && !axi.bvalid) begin
                if (b_wait == 0) begin axi.bvalid = 1'b1; axi.bresp = bresp_cfg; end
                else b_wait--;
            end
        end
    end

    // monitor
    bit arv_prev = 0;
    int ar_rise_cyc = 0;
    always @(negedge clk) begin
        if (resetn) begin
            if (axi.arvalid && !arv_prev) ar_rise_cyc = cyc;
            arv_prev = axi.arvalid;
            if (axi.arvalid && axi.arready) begin
                if (exp_ar.size() == 0) fail("ar_unexpected");
                else chk("araddr", 64'(axi.araddr), 64'(exp_ar.pop_front()));
                chk("arsize", 64'(axi.arsize), 64'd2);
            end
            if (axi.awvalid && axi.awready) begin
                if (exp_aw.size() == 0) fail("aw_unexpected");
                else chk("awaddr", 64'(axi.awaddr), 64'(exp_aw.pop_front()));
                chk("awsize", 64'(axi.awsize), 64'd2);
            end
            if (axi.wvalid && axi.wready) begin
                if (exp_w.size() == 0) fail("w_unexpected");
                else chk("wdata_strb_last", 64'({axi.wdata, axi.wstrb, axi.wlast}), 64'(exp_w.pop_front()));
            end
            if (core.req_rvalid) begin
                if (exp_rd.size() == 0) fail("rvalid_unexpected");
                else chk("req_rdata", 64'(core.req_rdata), 64'(exp_rd.pop_front()));
            end
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int max_wait, output int waited);
        core.req_wen = 1'b1; core.req_addr = a; core.req_wdata = d; core.req_wsel = s;
        waited = 0;
        @(negedge clk);
        while (!core.req_bvalid && waited < max_wait) begin @(negedge clk); waited++; end
        @(posedge clk); #1;
        core.req_wen = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input int max_wait, output int lat);
        core.req_ren = 1'b1; core.req_addr = a;
        lat = 0;
        @(negedge clk);
        while (!core.req_rvalid && lat < max_wait) begin @(negedge clk); lat++; end
        @(posedge clk); #1;
        core.req_ren = 1'b0;
    endtask

    task automatic wait_b(input int target, input int max_wait);
        int n = 0;
        while (n_b < target && n < max_wait) begin @(negedge clk); n++; end
        if (n_b < target) fail("b_timeout");
        @(posedge clk); #1;
    endtask

    initial begin : wdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, lat, cnt, nb0, nr0, nar0;
        core.req_ren = 0; core.req_wen = 0; core.req_wsel = '0; core.req_addr = '0;
        core.req_wdata = '0; core.req_flush = 0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_arvalid", 64'(axi.arvalid), 64'd0);
        chk("rst_awvalid", 64'(axi.awvalid), 64'd0);
        chk("rst_wvalid", 64'(axi.wvalid), 64'd0);
        chk("rst_rready", 64'(axi.rready), 64'd0);
        chk("rst_bready", 64'(axi.bready), 64'd0);
        chk("rst_req_rvalid", 64'(core.req_rvalid), 64'd0);
        chk("rst_req_rdata", 64'(core.req_rdata), 64'd0);
`ifdef LS_BRIDGE_ERR_EN
        chk("rst_bus_err", 64'(bus_err), 64'd0);
`endif
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk); #1;

        // single load, latency 3
        nar0 = n_ar;
        exp_ar.push_back(32'h40); rsrc.push_back(32'hDEADBEEF); exp_rd.push_back(32'hDEADBEEF);
        load(32'h40, 30, lat);
        chk("load_latency", 64'(lat), 64'd3);
        repeat (3) @(posedge clk); #1;
        chk("load_one_ar", 64'(n_ar - nar0), 64'd1);

        // five stores into a 4-deep buffer with AW/W stalled
        aw_rdy = 0; w_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            exp_aw.push_back(32'h200 + 32'(i * 4));
            exp_w.push_back({32'hA000_0000 + 32'(i), 4'hF, 1'b1});
            store(32'h200 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 3, w);
            chk("store_accept_immediate", 64'(w), 64'd0);
        end
        exp_aw.push_back(32'h210); exp_w.push_back({32'hA000_0004, 4'hF, 1'b1});
        core.req_wen = 1; core.req_addr = 32'h210; core.req_wdata = 32'hA000_0004; core.req_wsel = 4'hF;
        cnt = 0;
        repeat (6) begin @(negedge clk); if (core.req_bvalid) cnt++; end
        chk("full_stall", 64'(cnt), 64'd0);
        @(posedge clk); #1;
        nb0 = n_b;
        aw_rdy = 1; w_rdy = 1;
        cnt = 0;
        @(negedge clk);
        while (!core.req_bvalid && cnt < 40) begin @(negedge clk); cnt++; end
        chk("fifth_after_first_b", 64'(n_b - nb0), 64'd1);
        @(posedge clk); #1;
        core.req_wen = 0;
        wait_b(nb0 + 5, 100);
        chk("aw_queue_drained", 64'(exp_aw.size()), 64'd0);

        // store then load to same address with delayed B
        b_dly = 10;
        exp_aw.push_back(32'h100); exp_w.push_back({32'h0000ABCD, 4'h3, 1'b1});
        store(32'h100, 32'h0000ABCD, 4'h3, 3, w);
        chk("store_0x100_accept", 64'(w), 64'd0);
        exp_ar.push_back(32'h100); rsrc.push_back(32'h1234ABCD); exp_rd.push_back(32'h1234ABCD);
        load(32'h100, 60, lat);
        chk("ar_two_after_b", 64'(ar_rise_cyc - b_cyc), 64'd2);
        b_dly = 0;

        // flush while in R_R
        r_dly = 4;
        nr0 = n_r;
        exp_ar.push_back(32'h300); rsrc.push_back(32'h55);
        core.req_ren = 1; core.req_addr = 32'h300;
        cnt = 0;
        @(negedge clk);
        while (!axi.rready && cnt < 20) begin @(negedge clk); cnt++; end
        if (!axi.rready) fail("rready_timeout");
        @(posedge clk); #1;
        core.req_flush = 1; core.req_ren = 0;
        @(posedge clk); #1;
        core.req_flush = 0;
        cnt = 0;
        repeat (12) begin @(negedge clk); if (core.req_rvalid) cnt++; end
        chk("flush_no_rvalid", 64'(cnt), 64'd0);
        chk("flush_r_handshake", 64'(n_r - nr0), 64'd1);
        @(posedge clk); #1;
        r_dly = 0;
        exp_ar.push_back(32'h304); rsrc.push_back(32'h66); exp_rd.push_back(32'h66);
        load(32'h304, 30, lat);
        chk("post_flush_latency", 64'(lat), 64'd3);

        // ren and wen together: store first
        b_dly = 3;
        exp_aw.push_back(32'h400); exp_w.push_back({32'hCAFE0001, 4'hF, 1'b1});
        exp_ar.push_back(32'h400); rsrc.push_back(32'h77); exp_rd.push_back(32'h77);
        core.req_ren = 1; core.req_wen = 1; core.req_addr = 32'h400;
        core.req_wdata = 32'hCAFE0001; core.req_wsel = 4'hF;
        @(negedge clk);
        chk("rw_bvalid_same_cycle", 64'(core.req_bvalid), 64'd1);
        @(posedge clk); #1;
        core.req_wen = 0;
        cnt = 0;
        @(negedge clk);
        while (!core.req_rvalid && cnt < 60) begin @(negedge clk); cnt++; end
        if (!core.req_rvalid) fail("rw_load_timeout");
        @(posedge clk); #1;
        core.req_ren = 0;
        chk("rw_ar_after_b", 64'(ar_rise_cyc - b_cyc), 64'd2);
        b_dly = 0;

        // error response on a store
        nb0 = n_b;
        bresp_cfg = 2'b10;
        exp_aw.push_back(32'h500); exp_w.push_back({32'h0BAD0BAD, 4'hF, 1'b1});
        store(32'h500, 32'h0BAD0BAD, 4'hF, 3, w);
        wait_b(nb0 + 1, 40);
        bresp_cfg = 2'b00;
        chk("err_store_completes", 64'(n_b - nb0), 64'd1);
        exp_aw.push_back(32'h504); exp_w.push_back({32'h00000001, 4'hF, 1'b1});
        store(32'h504, 32'h1, 4'hF, 3, w);
        wait_b(nb0 + 2, 40);
        repeat (2) @(posedge clk); #1;
`ifdef LS_BRIDGE_ERR_EN
        @(negedge clk);
        chk("bus_err_sticky", 64'(bus_err), 64'd1);
        @(posedge clk); #1;
        resetn = 0;
        @(negedge clk);
        chk("bus_err_cleared_by_reset", 64'(bus_err), 64'd0);
        @(posedge clk); #1;
        resetn = 1;
`endif

        chk("exp_ar_empty", 64'(exp_ar.size()), 64'd0);
        chk("exp_w_empty", 64'(exp_w.size()), 64'd0);
        chk("exp_rd_empty", 64'(exp_rd.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
